// File: rtl/axi_master_pkg.sv
// Shared types, AXI response codes and strobe/size helpers for the AXI burst master.
package axi_master_pkg;

   localparam int unsigned AXI_ID_BITS = 4;

   localparam logic [1:0] BURST_INC = 2'b01;

   localparam logic [2:0] OP_SB = 3'b000;
   localparam logic [2:0] OP_SH = 3'b001;
   localparam logic [2:0] OP_SW = 3'b010;

   localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
   localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
   localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
   localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

   localparam int unsigned IDLE_BIT = 0;
   localparam int unsigned AR_BIT   = 1;
   localparam int unsigned R_BIT    = 2;
   localparam int unsigned WR_BIT   = 3;
   localparam int unsigned B_BIT    = 4;

   typedef enum logic [4:0] {
      S_IDLE = 5'(1 << IDLE_BIT),
      S_AR   = 5'(1 << AR_BIT),
      S_R    = 5'(1 << R_BIT),
      S_WR   = 5'(1 << WR_BIT),
      S_B    = 5'(1 << B_BIT)
   } state_t;

   function automatic logic [2:0] full_size(input int unsigned data_w);
      return (data_w == 64) ? 3'd3 : 3'd2;
   endfunction

   function automatic logic [2:0] size_of(input logic [2:0] func3, input logic single,
                                          input int unsigned data_w);
      logic [2:0] s;
      s = full_size(data_w);
      if (single) begin
         case (func3)
            OP_SB:   s = 3'd0;
            OP_SH:   s = 3'd1;
            OP_SW:   s = 3'd2;
            default: s = full_size(data_w);
         endcase
      end
      return s;
   endfunction

   // Result is 8 lanes wide; callers keep the low data_w/8 lanes.
   function automatic logic [7:0] strb_gen(input logic [2:0] func3, input logic [2:0] addr,
                                           input int unsigned data_w);
      logic [7:0] s;
      if (data_w == 64) begin
         case (func3)
            OP_SB:   s = 8'h01 << addr;
            OP_SH:   s = 8'h03 << {addr[2:1], 1'b0};
            OP_SW:   s = 8'h0F << {addr[2], 2'b00};
            default: s = '1;
         endcase
      end else begin
         case (func3)
            OP_SB:   s = 8'h01 << addr[1:0];
            OP_SH:   s = 8'h03 << {addr[1], 1'b0};
            default: s = 8'h0F;
         endcase
      end
      return s;
   endfunction

endpackage

// File: rtl/axi_master_burst_wstrb_gen.sv
// Combinational WSTRB/AWSIZE generator: narrow stores for single beats, full width for bursts.
module axi_wstrb_gen
   import axi_master_pkg::*;
#(
   parameter int unsigned DATA_W = 32
) (
   input  logic [2:0]          func3,
   input  logic [2:0]          addr,
   input  logic                single,
   output logic [DATA_W/8-1:0] strb,
   output logic [2:0]          size
);

   localparam int unsigned STRB_W = DATA_W / 8;

   always_comb begin
      strb = '1;
      if (single)
         strb = STRB_W'(strb_gen(func3, addr, DATA_W));
      size = size_of(func3, single, DATA_W);
   end

endmodule

// File: rtl/axi_master_burst.sv
// AXI4 burst master: latches one request, runs AR/R or concurrent AW+W then B, reports done/err.
module axi_master_burst
   import axi_master_pkg::*;
#(
   parameter logic [AXI_ID_BITS-1:0] MASTER_ID = '0,
   parameter int unsigned            DATA_W    = 32,
   parameter int unsigned            ADDR_W    = 32,
   parameter int unsigned            MAX_LEN   = 16
) (
   input  logic                   clk,
   input  logic                   rstn,
   input  logic                   req_valid,
   output logic                   req_ready,
   input  logic                   req_write,
   input  logic [ADDR_W-1:0]      req_addr,
   input  logic [7:0]             req_len,
   input  logic [2:0]             req_type,
   input  logic                   wd_valid,
   output logic                   wd_ready,
   input  logic [DATA_W-1:0]      wd_data,
   output logic                   rd_valid,
   output logic [DATA_W-1:0]      rd_data,
   output logic                   rd_last,
   output logic                   done,
   output logic                   err,
   output logic [AXI_ID_BITS-1:0] awid,
   output logic [ADDR_W-1:0]      awaddr,
   output logic [7:0]             awlen,
   output logic [2:0]             awsize,
   output logic [1:0]             awburst,
   output logic                   awvalid,
   input  logic                   awready,
   output logic [DATA_W-1:0]      wdata,
   output logic [DATA_W/8-1:0]    wstrb,
   output logic                   wlast,
   output logic                   wvalid,
   input  logic                   wready,
   input  logic [1:0]             bresp,
   input  logic                   bvalid,
   output logic                   bready,
   output logic [AXI_ID_BITS-1:0] arid,
   output logic [ADDR_W-1:0]      araddr,
   output logic [7:0]             arlen,
   output logic [2:0]             arsize,
   output logic [1:0]             arburst,
   output logic                   arvalid,
   input  logic                   arready,
   input  logic [DATA_W-1:0]      rdata,
   input  logic [1:0]             rresp,
   input  logic                   rlast,
   input  logic                   rvalid,
   output logic                   rready
);

   localparam int unsigned CNT_W = $clog2(MAX_LEN) + 1;

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] addr_q;
   logic [7:0]        len_q;
   logic [2:0]        type_q;
   logic [CNT_W-1:0]  cnt;
   logic              aw_done, w_done, err_sticky;
   logic              beat_last, aw_fire, w_fire, r_bad;
   logic [DATA_W/8-1:0] w_strb;
   logic [2:0]        w_size;

   axi_wstrb_gen #(.DATA_W(DATA_W)) u_wstrb_gen (
      .func3  (type_q),
      .addr   (addr_q[2:0]),
      .single (len_q == 8'd0),
      .strb   (w_strb),
      .size   (w_size)
   );

   assign beat_last = (32'(cnt) == 32'(len_q));
   assign r_bad     = (rresp != AXI_RESP_OKAY) || (rlast != beat_last);

   assign awid    = MASTER_ID;
   assign arid    = MASTER_ID;
   assign awaddr  = addr_q;
   assign araddr  = addr_q;
   assign awlen   = len_q;
   assign arlen   = len_q;
   assign awburst = BURST_INC;
   assign arburst = BURST_INC;
   assign awsize  = w_size;
   assign arsize  = full_size(DATA_W);
   assign wdata   = wd_data;
   assign wstrb   = w_strb;
   assign rd_data = rdata;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state      <= S_IDLE;
         addr_q     <= '0;
         len_q      <= '0;
         type_q     <= '0;
         cnt        <= '0;
         aw_done    <= 1'b0;
         w_done     <= 1'b0;
         err_sticky <= 1'b0;
      end else begin
         state <= state_nxt;
         case (state)
            S_IDLE: if (req_valid) begin
               addr_q     <= req_addr;
               len_q      <= req_len;
               type_q     <= req_type;
               cnt        <= '0;
               aw_done    <= 1'b0;
               w_done     <= 1'b0;
               err_sticky <= 1'b0;
            end
            S_R: if (rvalid) begin
               cnt <= cnt + CNT_W'(1);
               if (r_bad) err_sticky <= 1'b1;
            end
            S_WR: begin
               if (aw_fire) aw_done <= 1'b1;
               if (w_fire) begin
                  cnt <= cnt + CNT_W'(1);
                  if (beat_last) w_done <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      state_nxt = state;
      req_ready = 1'b0;
      arvalid   = 1'b0;
      rready    = 1'b0;
      awvalid   = 1'b0;
      wvalid    = 1'b0;
      wlast     = 1'b0;
      wd_ready  = 1'b0;
      bready    = 1'b0;
      rd_valid  = 1'b0;
      rd_last   = 1'b0;
      done      = 1'b0;
      err       = 1'b0;
      aw_fire   = 1'b0;
      w_fire    = 1'b0;
      case (state)
         S_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) state_nxt = req_write ? S_WR : S_AR;
         end
         S_AR: begin
            arvalid = 1'b1;
            if (arready) state_nxt = S_R;
         end
         S_R: begin
            rready = 1'b1;
            if (rvalid) begin
               rd_valid = 1'b1;
               rd_last  = rlast;
               if (rlast) begin
                  done      = 1'b1;
                  err       = err_sticky | r_bad;
                  state_nxt = S_IDLE;
               end
            end
         end
         S_WR: begin
            awvalid  = !aw_done;
            wvalid   = wd_valid && !w_done;
            wlast    = beat_last;
            wd_ready = wready && !w_done;
            aw_fire  = awvalid && awready;
            w_fire   = wvalid && wready;
            // Either channel may finish first; also covers both finishing this cycle.
            if ((aw_done || aw_fire) && (w_done || (w_fire && beat_last)))
               state_nxt = S_B;
         end
         S_B: begin
            bready = 1'b1;
            if (bvalid) begin
               done      = 1'b1;
               err       = (bresp != AXI_RESP_OKAY);
               state_nxt = S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   len_in_range: assert property (@(posedge clk) disable iff (!rstn)
      (req_valid && req_ready) |-> (32'(req_len) <= MAX_LEN - 1));

endmodule

// File: tb/tb_axi_master_burst.sv
// Directed bench for axi_master_burst acting as a scripted AXI slave with hand-computed expectations.
module tb_axi_master_burst;
   import axi_master_pkg::*;

   logic        clk = 1'b0;
   logic        rstn;
   logic        req_valid, req_ready, req_write;
   logic [31:0] req_addr;
   logic [7:0]  req_len;
   logic [2:0]  req_type;
   logic        wd_valid, wd_ready;
   logic [31:0] wd_data;
   logic        rd_valid, rd_last, done, err;
   logic [31:0] rd_data;
   logic [3:0]  awid, arid;
   logic [31:0] awaddr, araddr, wdata, rdata;
   logic [7:0]  awlen, arlen;
   logic [2:0]  awsize, arsize;
   logic [1:0]  awburst, arburst, bresp, rresp;
   logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
   logic        arvalid, arready, rlast, rvalid, rready;
   logic [3:0]  wstrb;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   axi_master_burst #(.MASTER_ID(4'd0), .DATA_W(32), .ADDR_W(32), .MAX_LEN(16)) dut (
      .clk(clk), .rstn(rstn),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_len(req_len), .req_type(req_type),
      .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data),
      .rd_valid(rd_valid), .rd_data(rd_data), .rd_last(rd_last),
      .done(done), .err(err),
      .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
      .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
      .bresp(bresp), .bvalid(bvalid), .bready(bready),
      .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
      .arvalid(arvalid), .arready(arready),
      .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Presents a request for one cycle; returns at the negedge where the DUT is in AR or WR.
   task automatic issue(input logic w, input logic [31:0] a, input logic [7:0] l,
                        input logic [2:0] t);
      @(negedge clk);
      req_valid = 1'b1; req_write = w; req_addr = a; req_len = l; req_type = t;
      #1 check("req_ready", req_ready, 1);
      @(negedge clk);
      req_valid = 1'b0; req_addr = '0; req_len = '0; req_type = '0; req_write = 1'b0;
   endtask

   task automatic do_ar(input logic [31:0] a, input logic [7:0] l);
      arready = 1'b1;
      #1;
      check("arvalid", arvalid, 1);
      check("araddr", araddr, a);
      check("arlen", arlen, l);
      check("arsize", arsize, 2);
      check("arburst", arburst, 1);
      @(negedge clk);
      arready = 1'b0;
   endtask

   task automatic r_beat(input logic [31:0] d, input logic lst, input logic [1:0] rsp,
                         input logic exp_done, input logic exp_err);
      rvalid = 1'b1; rdata = d; rlast = lst; rresp = rsp;
      #1;
      check("rready", rready, 1);
      check("rd_valid", rd_valid, 1);
      check("rd_data", rd_data, d);
      check("rd_last", rd_last, lst);
      check("r_done", done, exp_done);
      if (exp_done) check("r_err", err, exp_err);
      @(negedge clk);
      rvalid = 1'b0; rlast = 1'b0; rresp = '0;
   endtask

   task automatic r_stall();
      #1;
      check("stall_rd_valid", rd_valid, 0);
      check("stall_done", done, 0);
      @(negedge clk);
   endtask

   task automatic b_resp(input logic [1:0] rsp, input logic exp_err);
      #1 check("bready", bready, 1);
      check("b_awvalid", awvalid, 0);
      check("b_wvalid", wvalid, 0);
      bvalid = 1'b1; bresp = rsp;
      #1;
      check("b_done", done, 1);
      check("b_err", err, exp_err);
      @(negedge clk);
      bvalid = 1'b0; bresp = '0;
      #1 check("idle_done", done, 0);
      check("idle_req_ready", req_ready, 1);
   endtask

   initial begin
      rstn = 1'b0;
      req_valid = 0; req_write = 0; req_addr = '0; req_len = '0; req_type = '0;
      wd_valid = 0; wd_data = '0; awready = 0; wready = 0; bresp = '0; bvalid = 0;
      arready = 0; rdata = '0; rresp = '0; rlast = 0; rvalid = 0;
      repeat (3) @(negedge clk);
      #1;
      check("rst_arvalid", arvalid, 0);
      check("rst_awvalid", awvalid, 0);
      check("rst_wvalid", wvalid, 0);
      check("rst_rready", rready, 0);
      check("rst_bready", bready, 0);
      check("rst_done", done, 0);
      check("rst_rd_valid", rd_valid, 0);
      rstn = 1'b1;

      // single-word read
      issue(1'b0, 32'h100, 8'd0, OP_SW);
      do_ar(32'h100, 8'd0);
      r_beat(32'hDEADBEEF, 1'b1, 2'b00, 1'b1, 1'b0);
      #1 check("rd_after_done", done, 0);

      // read burst of 4 with gaps before beats 1 and 2
      issue(1'b0, 32'h400, 8'd3, OP_SW);
      do_ar(32'h400, 8'd3);
      r_beat(32'd0, 1'b0, 2'b00, 1'b0, 1'b0);
      r_stall();
      r_beat(32'd1, 1'b0, 2'b00, 1'b0, 1'b0);
      r_stall();
      r_beat(32'd2, 1'b0, 2'b00, 1'b0, 1'b0);
      r_beat(32'd3, 1'b1, 2'b00, 1'b1, 1'b0);

      // premature RLAST on second beat
      issue(1'b0, 32'h500, 8'd3, OP_SW);
      do_ar(32'h500, 8'd3);
      r_beat(32'hA0, 1'b0, 2'b00, 1'b0, 1'b0);
      r_beat(32'hA1, 1'b1, 2'b00, 1'b1, 1'b1);

      // SB store: AW and W complete in the same cycle
      issue(1'b1, 32'h203, 8'd0, OP_SB);
      awready = 1; wready = 1; wd_valid = 1; wd_data = 32'hAB000000;
      #1;
      check("sb_awvalid", awvalid, 1);
      check("sb_awaddr", awaddr, 32'h203);
      check("sb_awlen", awlen, 0);
      check("sb_awsize", awsize, 0);
      check("sb_awburst", awburst, 1);
      check("sb_wvalid", wvalid, 1);
      check("sb_wstrb", wstrb, 4'b1000);
      check("sb_wlast", wlast, 1);
      check("sb_wdata", wdata, 32'hAB000000);
      check("sb_wd_ready", wd_ready, 1);
      @(negedge clk);
      awready = 0; wready = 0; wd_valid = 0;
      b_resp(2'b00, 1'b0);

      // SH store at addr 0x202
      issue(1'b1, 32'h202, 8'd0, OP_SH);
      awready = 1; wready = 1; wd_valid = 1; wd_data = 32'h12340000;
      #1;
      check("sh_awsize", awsize, 1);
      check("sh_wstrb", wstrb, 4'b1100);
      @(negedge clk);
      awready = 0; wready = 0; wd_valid = 0;
      b_resp(2'b00, 1'b0);

      // 8-beat burst: W finishes first, AW accepted three cycles later
      issue(1'b1, 32'h1000, 8'd7, OP_SB);
      wready = 1; wd_valid = 1;
      for (int i = 0; i < 8; i++) begin
         wd_data = 32'h1000 + i;
         #1;
         check($sformatf("wb_wvalid%0d", i), wvalid, 1);
         check($sformatf("wb_wdata%0d", i), wdata, 32'h1000 + i);
         check($sformatf("wb_wlast%0d", i), wlast, (i == 7));
         check($sformatf("wb_wstrb%0d", i), wstrb, 4'hF);
         check($sformatf("wb_awvalid%0d", i), awvalid, 1);
         if (i == 0) begin
            check("wb_awsize", awsize, 2);
            check("wb_awlen", awlen, 7);
         end
         @(negedge clk);
      end
      for (int i = 0; i < 3; i++) begin
         #1;
         check($sformatf("wb_hold_awvalid%0d", i), awvalid, 1);
         check($sformatf("wb_hold_wvalid%0d", i), wvalid, 0);
         check($sformatf("wb_hold_wd_ready%0d", i), wd_ready, 0);
         check($sformatf("wb_hold_bready%0d", i), bready, 0);
         @(negedge clk);
      end
      awready = 1;
      #1 check("wb_aw_fire", awvalid, 1);
      check("wb_not_b_yet", bready, 0);
      @(negedge clk);
      awready = 0; wready = 0; wd_valid = 0;
      b_resp(2'b00, 1'b0);

      // SW store answered with SLVERR
      issue(1'b1, 32'h300, 8'd0, OP_SW);
      awready = 1; wready = 1; wd_valid = 1; wd_data = 32'hCAFEF00D;
      #1;
      check("sw_awsize", awsize, 2);
      check("sw_wstrb", wstrb, 4'hF);
      @(negedge clk);
      awready = 0; wready = 0; wd_valid = 0;
      b_resp(2'b10, 1'b1);

      // reset during second read beat
      issue(1'b0, 32'h600, 8'd3, OP_SW);
      do_ar(32'h600, 8'd3);
      r_beat(32'hB0, 1'b0, 2'b00, 1'b0, 1'b0);
      rvalid = 1; rdata = 32'hB1; rlast = 0;
      #1 rstn = 1'b0;
      #1;
      check("arst_rready", rready, 0);
      check("arst_rd_valid", rd_valid, 0);
      check("arst_done", done, 0);
      check("arst_arvalid", arvalid, 0);
      check("arst_awvalid", awvalid, 0);
      check("arst_req_ready", req_ready, 1);
      @(negedge clk);
      rvalid = 0;
      rstn = 1'b1;
      @(negedge clk);
      #1 check("post_rst_done", done, 0);
      check("post_rst_rready", rready, 0);

      // recovery: plain read after the abort
      issue(1'b0, 32'h700, 8'd0, OP_SW);
      do_ar(32'h700, 8'd0);
      r_beat(32'h77, 1'b1, 2'b00, 1'b1, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

endmodule
